// File: rtl/rv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// rv_pkg: RV32 opcodes, instruction formats and immediate bounds
// Rev 1.0
//----------------------------------------------------------------------
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_R   = 3'd3,
    FMT_BAD = 3'd4
  } inst_fmt_t;

  localparam int IMM12_MIN  = -2048;
  localparam int IMM12_MAX  = 2047;
  localparam int BOFF13_MIN = -4096;
  localparam int BOFF13_MAX = 4094;

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// inst_encoder_if: field-bundle input and instruction-memory write port
// Rev 1.0
//----------------------------------------------------------------------
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_pack.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// inst_pack: format select, immediate range check and RV32 word packing
// Rev 1.0
//----------------------------------------------------------------------
module inst_pack
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output inst_fmt_t   fmt,
  output logic        legal,
  output logic [31:0] word
);
  logic signed [31:0] w_imm_s;
  logic               w_imm12_ok;
  logic               w_boff_ok;

  assign w_imm_s    = $signed(imm);
  assign w_imm12_ok = (w_imm_s >= IMM12_MIN) && (w_imm_s <= IMM12_MAX);
  assign w_boff_ok  = (w_imm_s >= BOFF13_MIN) && (w_imm_s <= BOFF13_MAX) && !imm[0];

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_LOAD, OP_IMM: fmt = FMT_I;
      OP_STORE:        fmt = FMT_S;
      OP_BRANCH:       fmt = FMT_B;
      OP_REG:          fmt = FMT_R;
      default:         fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    case (fmt)
      FMT_I: begin
        legal = w_imm12_ok;
        word  = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        legal = w_imm12_ok;
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        legal = w_boff_ok;
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_R: begin
        legal = 1'b1;
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// inst_encoder: packs field bundles and streams them into instruction memory
// Rev 1.0
//----------------------------------------------------------------------
module inst_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  inst_encoder_if.slave     bus,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            r_state;
  state_t            w_state_next;
  logic              w_in_ready;
  logic              w_done_set;
  logic              w_accept;
  logic              w_wr_done;
  logic              w_ok;
  inst_fmt_t         w_fmt;
  logic              w_legal;
  logic [31:0]       w_word;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_count;

  inst_pack u_pack (
    .opcode (bus.in_opcode),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .imm    (bus.in_imm),
    .fmt    (w_fmt),
    .legal  (w_legal),
    .word   (w_word)
  );

  assign w_ok      = w_legal && (w_fmt != FMT_BAD);
  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_wr_done = r_mem_we && bus.mem_ready;

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_in_ready = !r_mem_we || bus.mem_ready;
        if (w_in_ready && bus.in_valid && bus.in_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_mem_we || bus.mem_ready) begin
          w_done_set   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address register always points at the pending (or next) write location.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= 16'h0;
    end else begin
      r_done <= w_done_set;
      if (r_state == S_IDLE && start) begin
        r_addr  <= base_addr & c_align_mask;
        r_err   <= 1'b0;
        r_count <= 16'h0;
      end else begin
        if (w_wr_done) begin
          r_addr <= r_addr + ADDR_W'(4);
          if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
        if (w_accept && !w_ok) r_err <= 1'b1;
      end
      if (w_accept && w_ok) begin
        r_mem_we <= 1'b1;
        r_wdata  <= w_word;
      end else if (w_wr_done) begin
        r_mem_we <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign done          = r_done;
  assign err           = r_err;
  assign word_count    = r_count;
endmodule
`default_nettype wire
